// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver feeding the host-to-core load path.
// Recovers one byte per good frame and emits it with a one-cycle strobe.
// A frame whose stop bit reads low raises a one-cycle framing-error pulse
// instead, and the receiver then waits for the line to return high before
// looking for the next start bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       ferr,
    output logic       busy
);

    // Compare points for the bit-period counter: mid start bit and full bit.
    localparam logic [CNT_W-1:0] LP_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LP_FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rxState_t;

    rxState_t         r_state;
    logic             r_rxdS1;
    logic             r_rxdS;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rdata;
    logic             r_rdataValid;
    logic             r_ferr;

    // Two-flop synchronizer; both flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxdS1 <= 1'b1;
            r_rxdS  <= 1'b1;
        end else begin
            r_rxdS1 <= rxd;
            r_rxdS  <= r_rxdS1;
        end
    end

    // Frame FSM: finds the start bit, samples each bit at its centre and qualifies the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_rdata      <= '0;
            r_rdataValid <= 1'b0;
            r_ferr       <= 1'b0;
        end else begin
            r_rdataValid <= 1'b0;
            r_ferr       <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!r_rxdS) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == LP_HALF_LAST) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        if (!r_rxdS) begin
                            r_state <= DATA;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == LP_FULL_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rxdS, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_cnt == LP_FULL_LAST) begin
                        r_cnt <= '0;
                        if (r_rxdS) begin
                            r_rdata      <= r_shift;
                            r_rdataValid <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (r_rxdS) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdataValid;
    assign ferr        = r_ferr;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames driven into uart_rx at 16 clocks per bit.
// A monitor collects every strobe into a queue and models the downstream 8->32 concatenator.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       ferr;
    logic       busy;

    int         testsRun  = 0;
    int         failCount = 0;

    logic [7:0] rxQ[$];
    int         validCount = 0;
    int         ferrCount  = 0;
    int         longPulse  = 0;
    int         bothHigh   = 0;
    logic       prevValid  = 1'b0;
    logic       prevFerr   = 1'b0;
    logic [31:0] concatWord = '0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .ferr       (ferr),
        .busy       (busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor on the falling edge: logs received bytes, pulse widths and the concatenated word.
    always @(negedge clk) begin
        if (!rst) begin
            if (rdata_valid) begin
                rxQ.push_back(rdata);
                validCount++;
                concatWord = {concatWord[23:0], rdata};
                if (prevValid) longPulse++;
            end
            if (ferr) begin
                ferrCount++;
                if (prevFerr) longPulse++;
            end
            if (rdata_valid && ferr) bothHigh++;
            prevValid = rdata_valid;
            prevFerr  = ferr;
        end else begin
            prevValid = 1'b0;
            prevFerr  = 1'b0;
        end
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic holdBit(input logic val, input int cycles);
        rxd = val;
        repeat (cycles) @(negedge clk);
    endtask

    // Drives one whole frame; stretch adds one extra cycle to every other bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit stretch);
        holdBit(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            holdBit(data[i], CPB + ((stretch && (i % 2 == 0)) ? 1 : 0));
        end
        holdBit(stopBit, CPB + (stretch ? 1 : 0));
    endtask

    initial begin
        int          baseV;
        int          baseF;
        int          baseQ;
        logic [7:0]  expQ[$];
        logic [7:0]  b;
        logic [7:0]  seq4[4];

        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rdata", {24'h0, rdata}, 32'h0);
        checkOutput("reset_valid", {31'h0, rdata_valid}, 32'h0);
        checkOutput("reset_ferr", {31'h0, ferr}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        holdBit(1'b1, 5);

        // Single nominal frame.
        baseV = validCount;
        applyStimulus(8'h55, 1'b1, 1'b0);
        holdBit(1'b1, 4);
        checkOutput("t1_valid_count", validCount - baseV, 1);
        checkOutput("t1_rdata", {24'h0, rdata}, 32'h55);
        checkOutput("t1_ferr_count", ferrCount, 0);
        checkOutput("t1_busy_idle", {31'h0, busy}, 32'h0);

        // Four frames back to back.
        baseV = validCount;
        baseQ = rxQ.size();
        seq4  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 4; i++) applyStimulus(seq4[i], 1'b1, 1'b0);
        holdBit(1'b1, 4);
        checkOutput("t2_valid_count", validCount - baseV, 4);
        for (int i = 0; i < 4; i++) begin
            if (baseQ + i < rxQ.size()) b = rxQ[baseQ + i];
            else b = 8'hxx;
            checkOutput($sformatf("t2_byte%0d", i), {24'h0, b}, {24'h0, seq4[i]});
        end
        checkOutput("t2_concat_word", concatWord, 32'hDEADBEEF);

        // Short low glitch must not start a frame.
        baseV = validCount;
        baseF = ferrCount;
        holdBit(1'b0, 5);
        rxd = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checkOutput("t3_busy_cleared", {31'h0, busy}, 32'h0);
        holdBit(1'b1, 20);
        checkOutput("t3_no_valid", validCount - baseV, 0);
        checkOutput("t3_no_ferr", ferrCount - baseF, 0);

        // Framing error followed by a break, then a good frame.
        baseV = validCount;
        baseF = ferrCount;
        holdBit(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdBit(b8(8'h3C, i), CPB);
        holdBit(1'b0, 40);
        checkOutput("t4_busy_in_break", {31'h0, busy}, 32'h1);
        holdBit(1'b1, 20);
        checkOutput("t4_ferr_count", ferrCount - baseF, 1);
        checkOutput("t4_no_valid", validCount - baseV, 0);
        checkOutput("t4_rdata_held", {24'h0, rdata}, 32'hEF);
        applyStimulus(8'h81, 1'b1, 1'b0);
        holdBit(1'b1, 4);
        checkOutput("t4_valid_after", validCount - baseV, 1);
        checkOutput("t4_rdata_81", {24'h0, rdata}, 32'h81);
        checkOutput("t4_ferr_total", ferrCount - baseF, 1);

        // Reset in the middle of a frame.
        baseV = validCount;
        baseF = ferrCount;
        holdBit(1'b0, CPB);
        for (int i = 0; i < 3; i++) holdBit(b8(8'h0F, i), CPB);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        checkOutput("t5_rdata_zero", {24'h0, rdata}, 32'h0);
        checkOutput("t5_valid_zero", {31'h0, rdata_valid}, 32'h0);
        checkOutput("t5_ferr_zero", {31'h0, ferr}, 32'h0);
        checkOutput("t5_busy_zero", {31'h0, busy}, 32'h0);
        holdBit(1'b1, 3 * CPB);
        checkOutput("t5_no_pulse", (validCount - baseV) + (ferrCount - baseF), 0);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        holdBit(1'b1, 4);
        checkOutput("t5_rdata_a5", {24'h0, rdata}, 32'hA5);
        checkOutput("t5_valid_count", validCount - baseV, 1);

        // Slow transmitter, bits stretched to 16.5 clocks on average.
        baseV = validCount;
        baseF = ferrCount;
        applyStimulus(8'h96, 1'b1, 1'b1);
        holdBit(1'b1, 4);
        checkOutput("t6_rdata_96", {24'h0, rdata}, 32'h96);
        checkOutput("t6_ferr", ferrCount - baseF, 0);
        checkOutput("t6_valid_count", validCount - baseV, 1);

        // Random bytes with random idle gaps, compared against the sent sequence.
        baseV = validCount;
        baseQ = rxQ.size();
        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom);
            expQ.push_back(b);
            applyStimulus(b, 1'b1, 1'b0);
            holdBit(1'b1, int'($urandom_range(0, 20)));
        end
        holdBit(1'b1, 4);
        checkOutput("rand_valid_count", validCount - baseV, expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (baseQ + i < rxQ.size()) b = rxQ[baseQ + i];
            else b = 8'hxx;
            checkOutput($sformatf("rand_byte%0d", i), {24'h0, b}, {24'h0, expQ[i]});
        end

        checkOutput("pulse_width", longPulse, 0);
        checkOutput("valid_ferr_overlap", bothHigh, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    function automatic logic b8(input logic [7:0] v, input int i);
        return v[i];
    endfunction

endmodule
